// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: hazard-unit FSM states and operand-forwarding source encodings.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } pipe_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_RET = 2'b11
    } fwd_sel_e;

    localparam int STALL_CNT_W = 16;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Single-operand forwarding select: MEM beats WB beats the retire register, otherwise the register file.
module fwd_mux
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              mem_regwrite_i,
    input  logic              mem_memread_i,
    input  logic [ADDR_W-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_aluout_i,
    input  logic              wb_regwrite_i,
    input  logic [ADDR_W-1:0] wb_waddr_i,
    input  logic [DATA_W-1:0] wb_wdata_i,
    input  logic              ret_valid_i,
    input  logic [ADDR_W-1:0] ret_addr_i,
    input  logic [DATA_W-1:0] ret_data_i,
    output fwd_sel_e          sel_o,
    output logic [DATA_W-1:0] data_o
);

    logic addr_nz;
    assign addr_nz = (addr_i != '0);

    always_comb begin
        // NOTE: every output gets a default first so no path through the if-chain infers a latch.
        sel_o  = FWD_RF;
        data_o = rf_data_i;
        // A load's MEM-stage value is still the address, not the loaded data, so it is never forwarded.
        if (addr_nz && mem_regwrite_i && !mem_memread_i && (mem_waddr_i == addr_i)) begin
            sel_o  = FWD_MEM;
            data_o = mem_aluout_i;
        end else if (addr_nz && wb_regwrite_i && (wb_waddr_i == addr_i)) begin
            sel_o  = FWD_WB;
            data_o = wb_wdata_i;
        end else if (addr_nz && ret_valid_i && (ret_addr_i == addr_i)) begin
            sel_o  = FWD_RET;
            data_o = ret_data_i;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding plus load-use / memory-wait / interrupt-flush hazard control for a 5-stage pipeline.
module fwd_hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_SRC   = 2,
    parameter int TIMEOUT   = 255,
    parameter int FLUSH_CYC = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      intterupt,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr_ex,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_ex,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr_id,
    input  logic [NUM_SRC-1:0]        src_used_id,
    input  logic                      ex_memread,
    input  logic [ADDR_W-1:0]         ex_waddr,
    input  logic                      mem_regwrite,
    input  logic                      mem_memread,
    input  logic [ADDR_W-1:0]         mem_waddr,
    input  logic [DATA_W-1:0]         mem_aluout,
    input  logic                      mem_ready,
    input  logic                      wb_regwrite,
    input  logic [ADDR_W-1:0]         wb_waddr,
    input  logic [DATA_W-1:0]         wb_wdata,
    output logic [NUM_SRC*DATA_W-1:0] fwd_out,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall_front,
    output logic                      bubble,
    output logic                      stall_all,
    output logic                      flush,
    output logic                      mem_err,
    output logic [STALL_CNT_W-1:0]    stall_cnt
);

    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYC - 1);

    pipe_state_e              state_q, state_d;
    logic [7:0]               wait_cnt_q, wait_cnt_d;
    logic [7:0]               flush_cnt_q, flush_cnt_d;
    logic                     pend_q, pend_d;
    logic                     ret_valid_q, ret_valid_d;
    logic [ADDR_W-1:0]        ret_addr_q, ret_addr_d;
    logic [DATA_W-1:0]        ret_data_q, ret_data_d;
    logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic                     load_use;
    fwd_sel_e                 sel_w [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_mux #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_fwd_mux (
            .addr_i        (src_addr_ex[i*ADDR_W +: ADDR_W]),
            .rf_data_i     (src_data_ex[i*DATA_W +: DATA_W]),
            .mem_regwrite_i(mem_regwrite),
            .mem_memread_i (mem_memread),
            .mem_waddr_i   (mem_waddr),
            .mem_aluout_i  (mem_aluout),
            .wb_regwrite_i (wb_regwrite),
            .wb_waddr_i    (wb_waddr),
            .wb_wdata_i    (wb_wdata),
            .ret_valid_i   (ret_valid_q),
            .ret_addr_i    (ret_addr_q),
            .ret_data_i    (ret_data_q),
            .sel_o         (sel_w[i]),
            .data_o        (fwd_out[i*DATA_W +: DATA_W])
        );
        assign fwd_sel[i*2 +: 2] = sel_w[i];
    end

    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_used_id[i] && (src_addr_id[i*ADDR_W +: ADDR_W] == ex_waddr)) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use && ex_memread && (ex_waddr != '0);
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pend_d      = pend_q;
        stall_front = 1'b0;
        bubble      = 1'b0;
        stall_all   = 1'b0;
        flush       = 1'b0;
        mem_err     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (intterupt) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end else if (mem_memread && !mem_ready) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                    stall_all  = 1'b1;
                end else if (load_use) begin
                    stall_front = 1'b1;
                    bubble      = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (intterupt) begin
                    pend_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d     = (pend_q || intterupt) ? ST_FLUSH : ST_RUN;
                    flush_cnt_d = '0;
                end else begin
                    stall_all = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        mem_err     = 1'b1;
                        state_d     = ST_FLUSH;
                        flush_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (stall_all) begin
            stall_front = 1'b1;
        end
        if ((state_d == ST_FLUSH) && (state_q != ST_FLUSH)) begin
            pend_d = 1'b0;
        end
    end

    // The retire register keeps the last WB write alive one extra cycle after it leaves the pipeline.
    always_comb begin
        ret_valid_d = ret_valid_q;
        ret_addr_d  = ret_addr_q;
        ret_data_d  = ret_data_q;
        if (flush) begin
            ret_valid_d = 1'b0;
        end else if (!stall_all) begin
            ret_valid_d = wb_regwrite && (wb_waddr != '0);
            ret_addr_d  = wb_waddr;
            ret_data_d  = wb_wdata;
        end
    end

    assign stall_cnt_d = (stall_front || stall_all) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    assign stall_cnt   = stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
            pend_q      <= 1'b0;
            ret_valid_q <= 1'b0;
            ret_addr_q  <= '0;
            ret_data_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            pend_q      <= pend_d;
            ret_valid_q <= ret_valid_d;
            ret_addr_q  <= ret_addr_d;
            ret_data_q  <= ret_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboarded bench: two hazard units (long/short timeout) share stimulus and are checked against a reference model.
module tb_fwd_hazard_unit;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NS   = 2;
    localparam int TO_A = 8;
    localparam int FC_A = 2;
    localparam int TO_B = 3;
    localparam int FC_B = 3;

    typedef struct {
        bit                      rst_n;
        bit                      intr;
        logic [NS-1:0][AW-1:0]   ex_addr;
        logic [NS-1:0][DW-1:0]   ex_data;
        logic [NS-1:0][AW-1:0]   id_addr;
        logic [NS-1:0]           id_used;
        bit                      ex_memread;
        logic [AW-1:0]           ex_waddr;
        bit                      mem_regwrite;
        bit                      mem_memread;
        bit                      mem_ready;
        logic [AW-1:0]           mem_waddr;
        logic [DW-1:0]           mem_aluout;
        bit                      wb_regwrite;
        logic [AW-1:0]           wb_waddr;
        logic [DW-1:0]           wb_wdata;
    } stim_t;

    typedef struct packed {
        logic [NS-1:0][DW-1:0] fwd_out;
        logic [NS-1:0][1:0]    sel;
        logic [4:0]            ctl;   // {stall_front, bubble, stall_all, flush, mem_err}
        logic [15:0]           cnt;
    } exp_t;

    typedef struct {
        int            waited;      // MEM_WAIT cycles already spent, -1 when not waiting
        int            flush_left;  // remaining flush cycles
        bit            pend;
        bit            rv;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        int            stalls;
    } mdl_t;

    logic              clk;
    logic              rst_n;
    logic              intterupt;
    logic [NS*AW-1:0]  src_addr_ex, src_addr_id;
    logic [NS*DW-1:0]  src_data_ex;
    logic [NS-1:0]     src_used_id;
    logic              ex_memread, mem_regwrite, mem_memread, mem_ready, wb_regwrite;
    logic [AW-1:0]     ex_waddr, mem_waddr, wb_waddr;
    logic [DW-1:0]     mem_aluout, wb_wdata;

    logic [NS*DW-1:0]  a_fwd_out, b_fwd_out;
    logic [NS*2-1:0]   a_fwd_sel, b_fwd_sel;
    logic              a_sf, a_bb, a_sa, a_fl, a_err;
    logic              b_sf, b_bb, b_sa, b_fl, b_err;
    logic [15:0]       a_cnt, b_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    mdl_t ma, mb;

    fwd_hazard_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .TIMEOUT(TO_A), .FLUSH_CYC(FC_A)) dut_a (
        .clk(clk), .reset(rst_n), .intterupt(intterupt),
        .src_addr_ex(src_addr_ex), .src_data_ex(src_data_ex),
        .src_addr_id(src_addr_id), .src_used_id(src_used_id),
        .ex_memread(ex_memread), .ex_waddr(ex_waddr),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_waddr(mem_waddr),
        .mem_aluout(mem_aluout), .mem_ready(mem_ready),
        .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .fwd_out(a_fwd_out), .fwd_sel(a_fwd_sel),
        .stall_front(a_sf), .bubble(a_bb), .stall_all(a_sa), .flush(a_fl), .mem_err(a_err),
        .stall_cnt(a_cnt)
    );

    fwd_hazard_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .TIMEOUT(TO_B), .FLUSH_CYC(FC_B)) dut_b (
        .clk(clk), .reset(rst_n), .intterupt(intterupt),
        .src_addr_ex(src_addr_ex), .src_data_ex(src_data_ex),
        .src_addr_id(src_addr_id), .src_used_id(src_used_id),
        .ex_memread(ex_memread), .ex_waddr(ex_waddr),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_waddr(mem_waddr),
        .mem_aluout(mem_aluout), .mem_ready(mem_ready),
        .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .fwd_out(b_fwd_out), .fwd_sel(b_fwd_sel),
        .stall_front(b_sf), .bubble(b_bb), .stall_all(b_sa), .flush(b_fl), .mem_err(b_err),
        .stall_cnt(b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_init();
        mdl_t m;
        m.waited     = -1;
        m.flush_left = 0;
        m.pend       = 1'b0;
        m.rv         = 1'b0;
        m.ra         = '0;
        m.rd         = '0;
        m.stalls     = 0;
        return m;
    endfunction

    // Reference behaviour for one clock cycle: outputs for the current inputs, then the state after the edge.
    task automatic model_step(input stim_t s, input int to, input int fc, inout mdl_t m, output exp_t e);
        mdl_t          n;
        bit            sf, bb, sa, fl, er, lu;
        logic [AW-1:0] a;
        if (!s.rst_n) m = mdl_init();
        e = '0;
        for (int i = 0; i < NS; i++) begin
            a = s.ex_addr[i];
            e.sel[i]     = 2'b00;
            e.fwd_out[i] = s.ex_data[i];
            if (a != 0) begin
                if (s.mem_regwrite && !s.mem_memread && s.mem_waddr == a) begin
                    e.sel[i] = 2'b01; e.fwd_out[i] = s.mem_aluout;
                end else if (s.wb_regwrite && s.wb_waddr == a) begin
                    e.sel[i] = 2'b10; e.fwd_out[i] = s.wb_wdata;
                end else if (m.rv && m.ra == a) begin
                    e.sel[i] = 2'b11; e.fwd_out[i] = m.rd;
                end
            end
        end
        lu = 1'b0;
        for (int i = 0; i < NS; i++)
            if (s.id_used[i] && s.id_addr[i] == s.ex_waddr) lu = 1'b1;
        lu = lu && s.ex_memread && (s.ex_waddr != 0);
        {sf, bb, sa, fl, er} = 5'b0;
        n = m;
        if (m.flush_left > 0) begin
            fl = 1'b1;
            n.flush_left = m.flush_left - 1;
        end else if (m.waited >= 0) begin
            if (s.intr) n.pend = 1'b1;
            if (s.mem_ready) begin
                n.waited = -1;
                if (m.pend || s.intr) n.flush_left = fc;
                n.pend = 1'b0;
            end else begin
                sa = 1'b1;
                if (m.waited + 1 == to) begin
                    er = 1'b1;
                    n.waited = -1;
                    n.flush_left = fc;
                    n.pend = 1'b0;
                end else begin
                    n.waited = m.waited + 1;
                end
            end
        end else begin
            if (s.intr) n.flush_left = fc;
            else if (s.mem_memread && !s.mem_ready) begin
                sa = 1'b1;
                n.waited = 0;
            end else if (lu) begin
                sf = 1'b1; bb = 1'b1;
            end
        end
        if (sa) sf = 1'b1;
        if (fl) n.rv = 1'b0;
        else if (!sa) begin
            n.rv = s.wb_regwrite && (s.wb_waddr != 0);
            n.ra = s.wb_waddr;
            n.rd = s.wb_wdata;
        end
        e.cnt = 16'(m.stalls);
        if (sf || sa) n.stalls = (m.stalls < 65535) ? m.stalls + 1 : 65535;
        e.ctl = {sf, bb, sa, fl, er};
        m = s.rst_n ? n : mdl_init();
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst_n        = 1'b1;
        s.intr         = 1'b0;
        s.ex_addr      = '0;
        s.ex_data      = {32'h2222_2222, 32'h1111_1111};
        s.id_addr      = '0;
        s.id_used      = '0;
        s.ex_memread   = 1'b0;
        s.ex_waddr     = '0;
        s.mem_regwrite = 1'b0;
        s.mem_memread  = 1'b0;
        s.mem_ready    = 1'b1;
        s.mem_waddr    = '0;
        s.mem_aluout   = '0;
        s.wb_regwrite  = 1'b0;
        s.wb_waddr     = '0;
        s.wb_wdata     = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim(input int ready_bias);
        stim_t s;
        s.rst_n = ($urandom_range(0, 299) != 0);
        s.intr  = ($urandom_range(0, 24) == 0);
        for (int i = 0; i < NS; i++) begin
            s.ex_addr[i] = AW'($urandom_range(0, 7));
            s.ex_data[i] = $urandom();
            s.id_addr[i] = AW'($urandom_range(0, 7));
            s.id_used[i] = 1'($urandom_range(0, 1));
        end
        s.ex_memread   = ($urandom_range(0, 2) == 0);
        s.ex_waddr     = AW'($urandom_range(0, 7));
        s.mem_regwrite = 1'($urandom_range(0, 1));
        s.mem_memread  = ($urandom_range(0, 3) == 0);
        s.mem_ready    = ($urandom_range(0, ready_bias) == 0);
        s.mem_waddr    = AW'($urandom_range(0, 7));
        s.mem_aluout   = $urandom();
        s.wb_regwrite  = 1'($urandom_range(0, 1));
        s.wb_waddr     = AW'($urandom_range(0, 7));
        s.wb_wdata     = $urandom();
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst_n        = s.rst_n;
        intterupt    = s.intr;
        src_addr_ex  = s.ex_addr;
        src_data_ex  = s.ex_data;
        src_addr_id  = s.id_addr;
        src_used_id  = s.id_used;
        ex_memread   = s.ex_memread;
        ex_waddr     = s.ex_waddr;
        mem_regwrite = s.mem_regwrite;
        mem_memread  = s.mem_memread;
        mem_ready    = s.mem_ready;
        mem_waddr    = s.mem_waddr;
        mem_aluout   = s.mem_aluout;
        wb_regwrite  = s.wb_regwrite;
        wb_waddr     = s.wb_waddr;
        wb_wdata     = s.wb_wdata;
    endtask

    task automatic cycle(input stim_t s);
        exp_t ea, eb;
        @(posedge clk);
        #1;
        apply(s);
        model_step(s, TO_A, FC_A, ma, ea);
        model_step(s, TO_B, FC_B, mb, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [NS*DW-1:0] fo,
                           input logic [NS*2-1:0] fs, input logic [4:0] ctl, input logic [15:0] cnt);
        check({tag, ".fwd_out"}, 64'(fo), 64'(e.fwd_out));
        check({tag, ".fwd_sel"}, 64'(fs), 64'(e.sel));
        check({tag, ".ctl"}, 64'(ctl), 64'(e.ctl));
        check({tag, ".stall_cnt"}, 64'(cnt), 64'(e.cnt));
    endtask

    // Monitor: every cycle with a pending expectation is compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                compare("a", e, a_fwd_out, a_fwd_sel, {a_sf, a_bb, a_sa, a_fl, a_err}, a_cnt);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                compare("b", e, b_fwd_out, b_fwd_sel, {b_sf, b_bb, b_sa, b_fl, b_err}, b_cnt);
            end
        end
    end

    initial begin
        stim_t s;
        int    base;
        int    bias;
        ma = mdl_init();
        mb = mdl_init();
        s = idle_stim();
        s.rst_n = 1'b0;
        apply(s);

        // Reset state, with forwarding still live from the register file.
        repeat (3) cycle(s);
        s.ex_addr[0] = 5'd4;
        s.ex_data[0] = 32'h0BAD_F00D;
        cycle(s);
        settle();
        check("rst.stall_cnt", 64'(a_cnt), 64'd0);
        check("rst.flush", 64'(a_fl), 64'd0);
        check("rst.fwd_rf", 64'(a_fwd_out[31:0]), 64'h0BAD_F00D);
        cycle(idle_stim());

        // MEM has priority over WB for the same register.
        s = idle_stim();
        s.ex_addr[0] = 5'd5;
        s.mem_regwrite = 1'b1; s.mem_waddr = 5'd5; s.mem_aluout = 32'hAAAA;
        s.wb_regwrite  = 1'b1; s.wb_waddr  = 5'd5; s.wb_wdata   = 32'hBBBB;
        cycle(s);
        settle();
        check("mem_prio.sel", 64'(a_fwd_sel[1:0]), 64'd1);
        check("mem_prio.out", 64'(a_fwd_out[31:0]), 64'hAAAA);

        // Writes to r0 never forward.
        s.ex_addr = '0; s.mem_waddr = '0; s.wb_waddr = '0;
        cycle(s);
        settle();
        check("r0.sel", 64'(a_fwd_sel), 64'd0);
        check("r0.out", 64'(a_fwd_out[31:0]), 64'h1111_1111);

        // Retire register forwards a write that has just left WB.
        s = idle_stim();
        s.wb_regwrite = 1'b1; s.wb_waddr = 5'd7; s.wb_wdata = 32'h1234; s.ex_addr[0] = 5'd1;
        cycle(s);
        s = idle_stim();
        s.ex_addr[0] = 5'd7;
        cycle(s);
        settle();
        check("ret.sel", 64'(a_fwd_sel[1:0]), 64'd3);
        check("ret.out", 64'(a_fwd_out[31:0]), 64'h1234);

        // Load-use stall lasts one cycle.
        base = ma.stalls;
        s = idle_stim();
        s.ex_memread = 1'b1; s.ex_waddr = 5'd3; s.id_addr[0] = 5'd3; s.id_used = 2'b01;
        cycle(s);
        settle();
        check("lu.stall_front", 64'(a_sf), 64'd1);
        check("lu.bubble", 64'(a_bb), 64'd1);
        check("lu.stall_all", 64'(a_sa), 64'd0);
        cycle(idle_stim());
        settle();
        check("lu.released", 64'(a_sf), 64'd0);
        check("lu.stall_cnt", 64'(a_cnt), 64'(base + 1));

        // Memory wait of four cycles; the short-timeout unit times out on the fourth.
        s = idle_stim();
        s.wb_regwrite = 1'b1; s.wb_waddr = 5'd9; s.wb_wdata = 32'hCAFE;
        cycle(s);
        base = ma.stalls;
        s = idle_stim();
        s.mem_memread = 1'b1; s.mem_ready = 1'b0; s.ex_addr[0] = 5'd9;
        s.wb_regwrite = 1'b1; s.wb_waddr = 5'd10; s.wb_wdata = 32'hDEAD;
        for (int k = 1; k <= 4; k++) begin
            cycle(s);
            settle();
            check($sformatf("mw%0d.stall_all", k), 64'(a_sa), 64'd1);
            check($sformatf("mw%0d.ret_held", k), 64'(a_fwd_out[31:0]), 64'hCAFE);
            check($sformatf("mw%0d.b_mem_err", k), 64'(b_err), (k == 4) ? 64'd1 : 64'd0);
        end
        s.mem_ready = 1'b1; s.wb_regwrite = 1'b0;
        cycle(s);
        settle();
        check("mw5.stall_all", 64'(a_sa), 64'd0);
        check("mw5.ret_sel", 64'(a_fwd_sel[1:0]), 64'd3);
        check("to.flush1", 64'(b_fl), 64'd1);
        s = idle_stim();
        s.ex_addr[0] = 5'd9;
        cycle(s);
        settle();
        check("mw.stall_cnt", 64'(a_cnt), 64'(base + 4));
        check("to.flush2", 64'(b_fl), 64'd1);
        cycle(s);
        settle();
        check("to.flush3", 64'(b_fl), 64'd1);
        cycle(s);
        settle();
        check("to.flush_end", 64'(b_fl), 64'd0);
        check("to.ret_invalid", 64'(b_fwd_sel[1:0]), 64'd0);

        // Interrupt during a memory wait is deferred until mem_ready; reset aborts the flush.
        s = idle_stim();
        s.mem_memread = 1'b1; s.mem_ready = 1'b0;
        cycle(s);
        s.intr = 1'b1;
        cycle(s);
        settle();
        check("irq.no_flush_c2", 64'(a_fl), 64'd0);
        s.intr = 1'b0;
        cycle(s);
        settle();
        check("irq.no_flush_c3", 64'(a_fl), 64'd0);
        s.mem_ready = 1'b1;
        cycle(s);
        settle();
        check("irq.ready", 64'({a_fl, a_sa}), 64'd0);
        cycle(idle_stim());
        settle();
        check("irq.flush_a", 64'(a_fl), 64'd1);
        check("irq.flush_b", 64'(b_fl), 64'd1);
        s = idle_stim();
        s.rst_n = 1'b0;
        cycle(s);
        settle();
        check("irq.rst_abort_a", 64'(a_fl), 64'd0);
        check("irq.rst_abort_b", 64'(b_fl), 64'd0);
        cycle(idle_stim());
        settle();
        check("irq.run_after_rst", 64'(b_fl), 64'd0);

        // Randomised traffic with the memory-ready rate varied in bursts.
        bias = 1;
        for (int k = 0; k < 4000; k++) begin
            if (k % 64 == 0) bias = (k % 192 == 0) ? 5 : ((k % 128 == 0) ? 0 : 1);
            cycle(rand_stim(bias));
        end
        cycle(idle_stim());

        for (int k = 0; k < 10 && (q_a.size() + q_b.size()) != 0; k++) @(negedge clk);
        #1;
        check("drain", 64'(q_a.size() + q_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter DATA_W, 32, operand/result width.
REQ-002 Parameter ADDR_W, 5, register address width.
REQ-003 Parameter NUM_SRC, 2, operands forwarded per EX instruction.
REQ-004 Parameter TIMEOUT, 255, maximum MEM_WAIT cycles before error (range 1..255).
REQ-005 Parameter FLUSH_CYC, 2, flush pulse length in cycles (range 1..255).
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 intterupt  in  1  interrupt request, level.
REQ-009 src_addr_ex  in  NUM_SRC*ADDR_W  EX-stage operand addresses, operand i at [i*ADDR_W +: ADDR_W].
REQ-010 src_data_ex  in  NUM_SRC*DATA_W  register-file read data for the EX operands.
REQ-011 src_addr_id / src_used_id  in  NUM_SRC*ADDR_W / NUM_SRC  ID-stage operand addresses and used flags.
REQ-012 ex_memread, ex_waddr  in  1, ADDR_W  EX instruction is a load; its destination.
REQ-013 mem_regwrite, mem_memread, mem_waddr, mem_aluout, mem_ready  in  1,1,ADDR_W,DATA_W,1  MEM stage write info, load flag, load-data-ready handshake.
REQ-014 wb_regwrite, wb_waddr, wb_wdata  in  1, ADDR_W, DATA_W  WB stage write.
REQ-015 fwd_out / fwd_sel  out  NUM_SRC*DATA_W / NUM_SRC*2  forwarded operands and selected source.
REQ-016 stall_front, bubble, stall_all, flush, mem_err  out  1 each  hold PC+IF/ID; zero ID/EX control; hold all stages; flush pipeline; one-cycle timeout pulse.
REQ-017 stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-018 Per operand i, fwd_sel SHALL be (first match wins, address 0 never matches): 01 MEM if mem_regwrite & !mem_memread & mem_waddr==addr; 10 WB if wb_regwrite & wb_waddr==addr; 11 RET if ret_valid & ret_addr==addr; else 00; fwd_out mirrors the selection (mem_aluout, wb_wdata, ret_data, src_data_ex) combinationally.
REQ-019 Retire register (ret_valid, ret_addr, ret_data) SHALL capture wb_regwrite & wb_waddr!=0, wb_waddr, wb_wdata on every rising edge where stall_all==0; it SHALL hold while stall_all==1 and be invalidated while flush==1.
REQ-020 Load-use: stall_front=bubble=1 combinationally in RUN when ex_memread & ex_waddr!=0 & any used ID operand address equals ex_waddr; stall_all=0 on such a cycle, so the stall lasts one cycle.
REQ-021 FSM states RUN, MEM_WAIT, FLUSH; reset state RUN.
REQ-022 RUN: intterupt -> FLUSH (interrupt has priority over any stall); else mem_memread & !mem_ready -> MEM_WAIT, with stall_all=1 in that same cycle.
REQ-023 MEM_WAIT: stall_all=1 while !mem_ready; wait counter increments each cycle; mem_ready -> RUN (stall_all=0 that cycle); counter reaching TIMEOUT with !mem_ready -> mem_err=1 for one cycle, -> FLUSH.
REQ-024 intterupt asserted during MEM_WAIT SHALL set a pending flag; on exit to RUN the next state is FLUSH instead; pending cleared on entering FLUSH.
REQ-025 FLUSH: flush=1 for exactly FLUSH_CYC cycles (counter), stall_front=bubble=stall_all=0, then RUN.
REQ-026 When stall_all=1, stall_front=1 and bubble=0.
REQ-027 stall_cnt increments by 1 on each edge where stall_front|stall_all, saturating at 16'hFFFF.

Reset
REQ-028 While reset=0: state RUN, counters 0, pending 0, ret_valid 0, stall_cnt 0, flush/mem_err 0; fwd_out equals src_data_ex unless MEM/WB match.
REQ-029 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL abort immediately; the first cycle after release is RUN.

Structure
REQ-030 Shared package mips_pipe_pkg SHALL hold the FSM state enum and the fwd_sel encodings (FWD_RF=00, FWD_MEM=01, FWD_WB=10, FWD_RET=11).
REQ-031 One sub-module fwd_mux (single-operand priority compare/select), instantiated NUM_SRC times by generate.

Verification
REQ-032 MEM and WB both write r5, EX reads r5: mem_aluout=0xAAAA, wb_wdata=0xBBBB -> fwd_sel=01, fwd_out=0xAAAA; r0 writes never forward.
REQ-033 WB writes r7=0x1234, next cycle EX reads r7 with no MEM/WB match -> fwd_sel=11, fwd_out=0x1234.
REQ-034 Load r3 in EX, ID uses r3 -> stall_front=bubble=1 for exactly 1 cycle; stall_cnt +1.
REQ-035 Load in MEM, mem_ready low 4 cycles -> stall_all=1 for 4 cycles, RUN on cycle 5; stall_cnt +4; ret register unchanged.
REQ-036 TIMEOUT=3, mem_ready never rises -> mem_err pulse, flush=1 for FLUSH_CYC cycles, ret_valid=0.
REQ-037 intterupt during MEM_WAIT -> no flush until mem_ready, then flush for FLUSH_CYC cycles; reset mid-flush -> flush=0 immediately.
